lsu: RTL

- Load/store unit sitting between the execute stage and the data memory port.
- Takes one decoded memory op (lw/lbu/sw/sb) with its effective address and store data.
- Issues a single word-aligned request over a valid/ready memory channel, waits for the response, and extracts/zero-extends load data.
- Hands the result to write-back over a valid/ready output channel. One op in flight; multi-cycle, backpressure-tolerant.

---
 rtl/lsu.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// lsu: load/store unit between execute and the data memory port.
//   Accepts one lw/lbu/sw/sb op, issues one word-aligned memory request,
//   waits for the response/ack, then presents the result to write-back.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        op handshake (is_lw/is_lbu/is_sw/is_sb, addr, st_data)
//   mem_req_*                request channel (valid/ready, addr, wen, wmask, wdata)
//   mem_resp_valid/data      response channel (ack for stores, read word for loads)
//   out_valid/out_ready      result handshake (out_rdata, out_is_load, out_err)
// Optional: define LSU_TIMEOUT_EN to abort WAIT after TIMEOUT cycles with out_err=1.
module lsu #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              is_lw,
  input  logic              is_lbu,
  input  logic              is_sw,
  input  logic              is_sb,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       st_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [3:0]        mem_req_wmask,
  output logic [31:0]       mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_rdata,
  output logic              out_is_load,
  output logic              out_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;
  typedef enum logic [2:0] {OP_NONE, OP_LW, OP_LBU, OP_SW, OP_SB} op_t;

  state_t            state, state_nxt;
  op_t               op_dec, op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       st_data_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              misalign;
  logic              timeout_hit;
  logic [7:0]        sel_byte;
  logic [31:0]       load_val;

  // Op decode with fixed priority lw > lbu > sw > sb.
  always_comb begin
    op_dec = OP_NONE;
    if (is_lw)       op_dec = OP_LW;
    else if (is_lbu) op_dec = OP_LBU;
    else if (is_sw)  op_dec = OP_SW;
    else if (is_sb)  op_dec = OP_SB;
  end

  // Only word ops can be misaligned; such ops skip memory and go straight to RESP.
  assign misalign = ((op_dec == OP_LW) || (op_dec == OP_SW)) && (addr[1:0] != 2'b00);

  // Byte lane selection for lbu uses the latched low address bits.
  always_comb begin
    sel_byte = mem_resp_data[7:0];
    case (addr_q[1:0])
      2'd0: sel_byte = mem_resp_data[7:0];
      2'd1: sel_byte = mem_resp_data[15:8];
      2'd2: sel_byte = mem_resp_data[23:16];
      2'd3: sel_byte = mem_resp_data[31:24];
      default: sel_byte = mem_resp_data[7:0];
    endcase
  end

  always_comb begin
    load_val = 32'd0;
    if (op_q == OP_LW)       load_val = mem_resp_data;
    else if (op_q == OP_LBU) load_val = {24'd0, sel_byte};
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] wait_cnt;

  // Held at zero while in REQ so it starts from zero on entering WAIT.
  always_ff @(posedge clk) begin
    if (rst)                  wait_cnt <= '0;
    else if (state == S_REQ)  wait_cnt <= '0;
    else if (state == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
  end

  // True on the WAIT cycle whose increment brings the count to TIMEOUT.
  assign timeout_hit = (state == S_WAIT) && (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    in_ready      = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    mem_req_wen   = 1'b0;
    mem_req_wmask = 4'b0000;
    mem_req_wdata = 32'd0;
    out_valid     = 1'b0;
    out_rdata     = 32'd0;
    out_is_load   = 1'b0;
    out_err       = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (op_dec == OP_NONE || misalign) state_nxt = S_RESP;
          else                               state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {addr_q[ADDR_W-1:2], 2'b00};
        if (op_q == OP_SW) begin
          mem_req_wen   = 1'b1;
          mem_req_wmask = 4'b1111;
          mem_req_wdata = st_data_q;
        end else if (op_q == OP_SB) begin
          mem_req_wen   = 1'b1;
          mem_req_wmask = 4'b0001 << addr_q[1:0];
          mem_req_wdata = {4{st_data_q[7:0]}};
        end
        if (mem_req_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A response on the timeout cycle still completes normally.
        if (mem_resp_valid || timeout_hit) state_nxt = S_RESP;
      end
      S_RESP: begin
        out_valid   = 1'b1;
        out_rdata   = rdata_q;
        out_is_load = (op_q == OP_LW) || (op_q == OP_LBU);
        out_err     = err_q;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= OP_NONE;
      addr_q    <= '0;
      st_data_q <= 32'd0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      if (state == S_IDLE && in_valid) begin
        op_q      <= op_dec;
        addr_q    <= addr;
        st_data_q <= st_data;
        rdata_q   <= 32'd0;
        err_q     <= misalign;
      end
      if (state == S_WAIT) begin
        if (mem_resp_valid) begin
          rdata_q <= load_val;
        end else if (timeout_hit) begin
          rdata_q <= 32'd0;
          err_q   <= 1'b1;
        end
      end
    end
  end

endmodule
